// File: rtl/score_pkg.sv
// Shared constants and FSM encoding for the score log controller.
package score_pkg;
    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CLEAR
    } state_e;
endpackage

// File: rtl/score_ring_ptr.sv
// Circular-log bookkeeping: write pointer, saturating entry count and
// newest-relative address lookup.
module score_ring_ptr
    import score_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] index_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W:0]   count_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              in_range_o
);
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (adv_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (count_q != CNT_FULL) begin
                count_d = count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Newest entry lives just behind the write pointer; wraps naturally.
    assign rd_addr_o  = wr_ptr_q - PTR_ONE - index_i;
    assign in_range_o = {1'b0, index_i} < count_q;
    assign wr_ptr_o   = wr_ptr_q;
    assign count_o    = count_q;
endmodule

// File: rtl/score_log_controller.sv
// Arbitrates the single-port score RAM between the logger and the display.
// Define SCORE_CLEAR_EN to add the clear_req/clear_done RAM wipe.
module score_log_controller
    import score_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SCORE_CLEAR_EN
    input  logic              clear_req,
    output logic              clear_done,
`endif
    input  logic              log_req,
    input  logic [DATA_W-1:0] log_data,
    output logic              log_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_index,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [DATA_W-1:0] high_score,
    output logic              new_hs,
    output logic              busy
);
    localparam logic [1:0]        LAT_INIT = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_e state_q, state_d;

    logic [1:0]        lat_q, lat_d;
    logic              log_ack_q, log_ack_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic [DATA_W-1:0] high_score_q, high_score_d;
    logic              new_hs_q, new_hs_d;
    logic              clear_done_d;
    logic              ptr_adv, ptr_clr;
    logic              clr_go;
    logic [ADDR_W-1:0] rd_addr;
    logic              in_range;

`ifdef SCORE_CLEAR_EN
    logic clear_done_q;
    assign clr_go     = clear_req;
    assign clear_done = clear_done_q;
`else
    assign clr_go = 1'b0;
`endif

    score_ring_ptr #(.ADDR_W(ADDR_W)) u_ptr (
        .clk       (clk),
        .reset     (reset),
        .adv_i     (ptr_adv),
        .clr_i     (ptr_clr),
        .index_i   (rd_index),
        .wr_ptr_o  (wr_ptr),
        .count_o   (count),
        .rd_addr_o (rd_addr),
        .in_range_o(in_range)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr_go) begin
                    state_d = S_CLEAR;
                end else if (log_req) begin
                    state_d = S_WRITE;
                end else if (rd_req && in_range) begin
                    state_d = S_READ;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                if (lat_q == 2'd0) begin
                    state_d = S_IDLE;
                end
            end
`ifdef SCORE_CLEAR_EN
            S_CLEAR: begin
                if (mem_address_q == ADDR_MAX) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lat_d         = lat_q;
        log_ack_d     = 1'b0;
        rd_valid_d    = 1'b0;
        rd_err_d      = 1'b0;
        rd_data_d     = rd_data_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        high_score_d  = high_score_q;
        new_hs_d      = 1'b0;
        clear_done_d  = 1'b0;
        ptr_adv       = 1'b0;
        ptr_clr       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clr_go) begin
                    mem_wren_d    = 1'b1;
                    mem_address_d = '0;
                    mem_data_d    = '0;
                end else if (log_req) begin
                    mem_wren_d    = 1'b1;
                    mem_address_d = wr_ptr;
                    mem_data_d    = log_data;
                    log_ack_d     = 1'b1;
                end else if (rd_req) begin
                    // Out-of-range reads answer at once without touching the RAM.
                    if (in_range) begin
                        mem_address_d = rd_addr;
                        lat_d         = LAT_INIT;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_err_d   = 1'b1;
                        rd_data_d  = '0;
                    end
                end
            end
            S_WRITE: begin
                ptr_adv = 1'b1;
                if (mem_data_q > high_score_q) begin
                    high_score_d = mem_data_q;
                    new_hs_d     = 1'b1;
                end
            end
            S_READ: begin
                if (lat_q == 2'd0) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_q;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
`ifdef SCORE_CLEAR_EN
            S_CLEAR: begin
                if (mem_address_q == ADDR_MAX) begin
                    ptr_clr      = 1'b1;
                    high_score_d = '0;
                    clear_done_d = 1'b1;
                end else begin
                    mem_wren_d    = 1'b1;
                    mem_address_d = mem_address_q + ADDR_ONE;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_q         <= '0;
            log_ack_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_err_q      <= 1'b0;
            rd_data_q     <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            high_score_q  <= '0;
            new_hs_q      <= 1'b0;
        end else begin
            lat_q         <= lat_d;
            log_ack_q     <= log_ack_d;
            rd_valid_q    <= rd_valid_d;
            rd_err_q      <= rd_err_d;
            rd_data_q     <= rd_data_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            high_score_q  <= high_score_d;
            new_hs_q      <= new_hs_d;
        end
    end

`ifdef SCORE_CLEAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= clear_done_d;
        end
    end
`endif

    assign log_ack     = log_ack_q;
    assign rd_valid    = rd_valid_q;
    assign rd_err      = rd_err_q;
    assign rd_data     = rd_data_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign high_score  = high_score_q;
    assign new_hs      = new_hs_q;
    assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_score_log_controller.sv
// Randomized self-checking bench for score_log_controller against a
// queue-based model of the score log and a registered-q RAM model.
`timescale 1ns/1ps
module tb_score_log_controller;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int RL    = 2;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          log_req = 1'b0;
    logic [DW-1:0] log_data = '0;
    logic          log_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_index = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr;
    logic [DW-1:0] high_score;
    logic          new_hs;
    logic          busy;
`ifdef SCORE_CLEAR_EN
    logic          clear_req = 1'b0;
    logic          clear_done;
`endif

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] q_r = '0;
    logic [DW-1:0] hist [$];
    logic [DW-1:0] m_hs;
    int            m_total;

    score_log_controller #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SCORE_CLEAR_EN
        .clear_req  (clear_req),
        .clear_done (clear_done),
`endif
        .log_req    (log_req),
        .log_data   (log_data),
        .log_ack    (log_ack),
        .rd_req     (rd_req),
        .rd_index   (rd_index),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q),
        .count      (count),
        .wr_ptr     (wr_ptr),
        .high_score (high_score),
        .new_hs     (new_hs),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // RAM with registered q: data appears the cycle after the address.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        q_r <= ram[mem_address];
    end
    assign mem_q = q_r;

    function automatic void model_clear();
        hist.delete();
        m_hs = '0;
        m_total = 0;
    endfunction

    function automatic void model_push(input logic [DW-1:0] v);
        hist.push_front(v);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        if (v > m_hs) m_hs = v;
        m_total++;
    endfunction

    function automatic logic [AW:0] model_count();
        return (AW+1)'(hist.size());
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        log_req = 1'b0;
        rd_req = 1'b0;
`ifdef SCORE_CLEAR_EN
        clear_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic do_append(input logic [DW-1:0] v, output int n,
                             output logic [AW-1:0] a, output logic [DW-1:0] d,
                             output logic w, output logic hs_p);
        log_req = 1'b1;
        log_data = v;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (log_ack) break;
        end
        a = mem_address;
        d = mem_data;
        w = mem_wren;
        log_req = 1'b0;
        @(negedge clk);
        hs_p = new_hs;
    endtask

    task automatic do_read(input logic [AW-1:0] idx, output int n,
                           output logic [DW-1:0] d, output logic e);
        rd_req = 1'b1;
        rd_index = idx;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (rd_valid) break;
        end
        d = rd_data;
        e = rd_err;
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [DW-1:0] d;
        logic e;
        apply_reset();
        checks++;
        if ({log_ack, rd_valid, rd_data, rd_err, mem_address, mem_data, mem_wren,
             count, wr_ptr, high_score, new_hs, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs count=%0d wr_ptr=%0d hs=%0d busy=%b wren=%b addr=%0d",
                     count, wr_ptr, high_score, busy, mem_wren, mem_address);
        end
        do_read(9'd0, n, d, e);
        checks++;
        if (n !== 1 || e !== 1'b1 || d !== '0) begin
            failures++;
            $display("FAIL empty_read lat=%0d err=%b data=%0d want lat=1 err=1 data=0", n, e, d);
        end
        checks++;
        if (mem_wren !== 1'b0 || mem_address !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_read_ram wren=%b addr=%0d busy=%b want 0 0 0",
                     mem_wren, mem_address, busy);
        end
    endtask

    task automatic test_append_basic();
        logic [DW-1:0] vals [3];
        int n;
        int hs_pulses;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic w, hp, e;
        vals[0] = 5; vals[1] = 12; vals[2] = 7;
        apply_reset();
        hs_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            do_append(vals[i], n, a, d, w, hp);
            checks++;
            if (n !== 1 || w !== 1'b1 || a !== AW'(i) || d !== vals[i]) begin
                failures++;
                $display("FAIL append_issue[%0d] lat=%0d wren=%b addr=%0d data=%0d want 1 1 %0d %0d",
                         i, n, w, a, d, i, vals[i]);
            end
            checks++;
            if (hp !== (vals[i] > m_hs)) begin
                failures++;
                $display("FAIL new_hs[%0d] got=%b want=%b", i, hp, vals[i] > m_hs);
            end
            if (hp === 1'b1) hs_pulses++;
            model_push(vals[i]);
        end
        checks++;
        if (count !== 10'd3 || high_score !== 32'd12 || hs_pulses != 2 || wr_ptr !== 9'd3) begin
            failures++;
            $display("FAIL append_state count=%0d hs=%0d pulses=%0d wr_ptr=%0d want 3 12 2 3",
                     count, high_score, hs_pulses, wr_ptr);
        end
        do_read(9'd0, n, d, e);
        checks++;
        if (n !== 1 + RL || e !== 1'b0 || d !== 32'd7) begin
            failures++;
            $display("FAIL read_idx0 lat=%0d err=%b data=%0d want %0d 0 7", n, e, d, 1 + RL);
        end
        do_read(9'd2, n, d, e);
        checks++;
        if (n !== 1 + RL || e !== 1'b0 || d !== 32'd5) begin
            failures++;
            $display("FAIL read_idx2 lat=%0d err=%b data=%0d want %0d 0 5", n, e, d, 1 + RL);
        end
        do_read(9'd3, n, d, e);
        checks++;
        if (n !== 1 || e !== 1'b1 || d !== '0) begin
            failures++;
            $display("FAIL read_idx3 lat=%0d err=%b data=%0d want 1 1 0", n, e, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v;
        logic got_ack, early_valid;
        int n;
        v = $urandom_range(1000, 5000);
        log_req = 1'b1;
        log_data = v;
        rd_req = 1'b1;
        rd_index = 9'd0;
        @(negedge clk);
        got_ack = log_ack;
        early_valid = rd_valid;
        log_req = 1'b0;
        model_push(v);
        checks++;
        if (got_ack !== 1'b1 || early_valid !== 1'b0) begin
            failures++;
            $display("FAIL priority ack=%b rd_valid=%b want 1 0", got_ack, early_valid);
        end
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (rd_valid) break;
        end
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== hist[0]) begin
            failures++;
            $display("FAIL priority_read valid=%b err=%b data=%0d want 1 0 %0d",
                     rd_valid, rd_err, rd_data, hist[0]);
        end
    endtask

    task automatic test_wrap();
        int n, bad;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic w, hp, e;
        apply_reset();
        bad = 0;
        for (int i = 1; i <= 514; i++) begin
            do_append(DW'(i), n, a, d, w, hp);
            if (n !== 1 || a !== AW'(m_total % DEPTH) || d !== DW'(i)) bad++;
            model_push(DW'(i));
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wrap_appends bad=%0d want 0", bad);
        end
        checks++;
        if (count !== model_count() || wr_ptr !== 9'd2 || high_score !== 32'd514) begin
            failures++;
            $display("FAIL wrap_state count=%0d wr_ptr=%0d hs=%0d want 512 2 514",
                     count, wr_ptr, high_score);
        end
        do_read(9'd0, n, d, e);
        checks++;
        if (e !== 1'b0 || d !== 32'd514) begin
            failures++;
            $display("FAIL wrap_idx0 err=%b data=%0d want 0 514", e, d);
        end
        do_read(9'd511, n, d, e);
        checks++;
        if (e !== 1'b0 || d !== 32'd3) begin
            failures++;
            $display("FAIL wrap_idx511 err=%b data=%0d want 0 3", e, d);
        end
    endtask

    task automatic test_reset_mid_read();
        int n, seen;
        logic [DW-1:0] d;
        logic e;
        rd_req = 1'b1;
        rd_index = 9'd0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_read_busy got=%b want 1", busy);
        end
        reset = 1'b1;
        rd_req = 1'b0;
        #1;
        checks++;
        if ({rd_valid, rd_data, rd_err, mem_address, mem_wren, count, wr_ptr,
             high_score, busy, log_ack} !== '0) begin
            failures++;
            $display("FAIL mid_read_reset count=%0d addr=%0d busy=%b hs=%0d",
                     count, mem_address, busy, high_score);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rd_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_read_abort rd_valid_seen=%0d want 0", seen);
        end
        do_read(9'd0, n, d, e);
        checks++;
        if (n !== 1 || e !== 1'b1 || d !== '0) begin
            failures++;
            $display("FAIL post_reset_read lat=%0d err=%b data=%0d want 1 1 0", n, e, d);
        end
    endtask

    task automatic test_random();
        int n, hi;
        logic [AW-1:0] a, idx;
        logic [DW-1:0] v, d;
        logic w, hp, e, exp_err;
        apply_reset();
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                v = ($urandom_range(0, 3) == 0) ? $urandom() : DW'($urandom_range(0, 1000));
                do_append(v, n, a, d, w, hp);
                checks++;
                if (n !== 1 || a !== AW'(m_total % DEPTH) || d !== v || hp !== (v > m_hs)) begin
                    failures++;
                    $display("FAIL rand_append[%0d] lat=%0d addr=%0d data=%0d new_hs=%b want 1 %0d %0d %b",
                             k, n, a, d, hp, m_total % DEPTH, v, v > m_hs);
                end
                model_push(v);
            end else begin
                hi = hist.size() + 2;
                if (hi > DEPTH - 1) hi = DEPTH - 1;
                idx = AW'($urandom_range(0, hi));
                exp_err = (int'(idx) >= hist.size());
                do_read(idx, n, d, e);
                checks++;
                if (e !== exp_err || n !== (exp_err ? 1 : 1 + RL) ||
                    d !== (exp_err ? '0 : hist[idx])) begin
                    failures++;
                    $display("FAIL rand_read[%0d] idx=%0d lat=%0d err=%b data=%0d want err=%b data=%0d",
                             k, idx, n, e, d, exp_err, exp_err ? '0 : hist[idx]);
                end
            end
        end
        checks++;
        if (count !== model_count() || high_score !== m_hs || wr_ptr !== AW'(m_total % DEPTH)) begin
            failures++;
            $display("FAIL rand_state count=%0d hs=%0d wr_ptr=%0d want %0d %0d %0d",
                     count, high_score, wr_ptr, hist.size(), m_hs, m_total % DEPTH);
        end
    endtask

`ifdef SCORE_CLEAR_EN
    task automatic test_clear();
        int n, wcnt, bad, cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic w, hp, done;
        apply_reset();
        do_append(32'd9, n, a, d, w, hp);
        model_push(32'd9);
        clear_req = 1'b1;
        wcnt = 0;
        bad = 0;
        done = 1'b0;
        cyc = 0;
        while (cyc < 600) begin
            @(negedge clk);
            clear_req = 1'b0;
            cyc++;
            if (mem_wren) begin
                if (mem_data !== '0 || mem_address !== AW'(wcnt) || busy !== 1'b1) bad++;
                wcnt++;
            end
            if (clear_done) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (done !== 1'b1 || wcnt != DEPTH || bad != 0) begin
            failures++;
            $display("FAIL clear_sweep done=%b wren_cycles=%0d bad=%0d want 1 %0d 0",
                     done, wcnt, bad, DEPTH);
        end
        model_clear();
        checks++;
        if (count !== '0 || high_score !== '0 || wr_ptr !== '0) begin
            failures++;
            $display("FAIL clear_state count=%0d hs=%0d wr_ptr=%0d want 0 0 0",
                     count, high_score, wr_ptr);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        model_clear();
        test_reset();
        test_append_basic();
        test_back_to_back();
        test_wrap();
        test_reset_mid_read();
        test_random();
`ifdef SCORE_CLEAR_EN
        test_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
